// File: rtl/load_extend_if.sv
// Request/result bundle for the load alignment and extension unit.
// The master side issues memory words and consumes extended results; the slave side is the unit.
interface load_extend_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [OFF_W-1:0]      in_off;
    logic [2:0]            in_op;
    logic [TAG_WIDTH-1:0]  in_tag;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_misaligned;
    logic                  out_illegal;

    modport master (
        output in_valid, in_data, in_off, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_misaligned, out_illegal
    );

    modport slave (
        input  in_valid, in_data, in_off, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_misaligned, out_illegal
    );
endinterface

// File: rtl/load_extend.sv
// Load-data alignment and sign/zero extension for RV32/RV64, with a two-entry
// (output + skid) registered valid/ready buffer so in_ready never depends on out_ready.
module load_extend #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    load_extend_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  misaligned;
        logic                  illegal;
    } result_t;

    // Encoding is {or_valid, sr_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL1 = 2'b10,
        FULL2 = 2'b11
    } state_t;

    state_t  state_q, state_d;
    result_t or_q, sr_q, new_res;

    logic or_valid, sr_valid;
    logic in_fire, out_fire;
    logic or_load_new, or_load_sr, sr_load;

    logic [OFF_W+2:0]      shamt;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] field_mask;
    logic [2:0]            off_ext;
    logic [2:0]            align_mask;
    logic                  sign_bit;
    logic                  illegal;
    logic                  misaligned;

    assign or_valid = state_q[1];
    assign sr_valid = state_q[0];

    assign bus.in_ready = rst_n && !sr_valid;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = or_valid && bus.out_ready;

    // Extension datapath: evaluated on the incoming request, ahead of the OR/SR writes.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        align_mask = 3'b000;
        field_mask = '1;
        sign_bit   = 1'b0;
        new_res    = '0;

        shamt   = {bus.in_off, 3'b000};
        lane    = bus.in_data >> shamt;
        off_ext = 3'(bus.in_off);

        illegal = (bus.in_op == 3'b111)
               || ((DATA_WIDTH == 32) && (bus.in_op == 3'b011))
               || ((DATA_WIDTH == 32) && (bus.in_op == 3'b110));

        case (bus.in_op[1:0])
            2'd0: begin
                align_mask = 3'b000;
                field_mask = DATA_WIDTH'(8'hFF);
                sign_bit   = lane[7];
            end
            2'd1: begin
                align_mask = 3'b001;
                field_mask = DATA_WIDTH'(16'hFFFF);
                sign_bit   = lane[15];
            end
            2'd2: begin
                align_mask = 3'b011;
                field_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                sign_bit   = lane[31];
            end
            default: begin
                align_mask = 3'b111;
                field_mask = '1;
                sign_bit   = lane[DATA_WIDTH-1];
            end
        endcase

        misaligned = !illegal && (|(off_ext & align_mask));

        // A full-width field leaves ~field_mask empty, so LW on RV32 and LD pass through untouched.
        new_res.data = (lane & field_mask)
                     | ({DATA_WIDTH{sign_bit & ~bus.in_op[2]}} & ~field_mask);
        if (illegal || misaligned) begin
            new_res.data = '0;
        end
        new_res.tag        = bus.in_tag;
        new_res.misaligned = misaligned;
        new_res.illegal    = illegal;
    end

    always_comb begin
        state_d     = state_q;
        or_load_new = 1'b0;
        or_load_sr  = 1'b0;
        sr_load     = 1'b0;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = FULL1;
                    or_load_new = 1'b1;
                end
            end
            FULL1: begin
                if (in_fire && out_fire) begin
                    or_load_new = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL2;
                    sr_load = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL2: begin
                if (out_fire) begin
                    state_d    = FULL1;
                    or_load_sr = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the payload registers are reset as well, because out_* must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q <= '0;
            sr_q <= '0;
        end else begin
            if (or_load_new) begin
                or_q <= new_res;
            end else if (or_load_sr) begin
                or_q <= sr_q;
            end
            if (sr_load) begin
                sr_q <= new_res;
            end
        end
    end

    assign bus.out_valid      = or_valid;
    assign bus.out_data       = or_q.data;
    assign bus.out_tag        = or_q.tag;
    assign bus.out_misaligned = or_q.misaligned;
    assign bus.out_illegal    = or_q.illegal;
endmodule

// File: tb/tb_load_extend.sv
// Bench for load_extend: an RV32 and an RV64 instance side by side, a directed vector table,
// hand-written buffering/reset sequences and a random stream checked against a queue model.
module tb_load_extend;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_extend_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus32 ();
    load_extend_if #(.DATA_WIDTH(64), .TAG_WIDTH(5)) bus64 ();

    load_extend #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    load_extend #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        mis;
        logic        ill;
    } res_t;

    typedef struct {
        bit          rv64;
        logic [2:0]  op;
        logic [2:0]  off;
        logic [63:0] data;
        logic [63:0] exp_data;
        bit          exp_mis;
        bit          exp_ill;
    } vec_t;

    int   vectors     = 0;
    int   miscompares = 0;
    res_t q32[$];
    res_t q64[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: field = bytes [off, off+size) of the word, then signed or unsigned reinterpretation.
    function automatic res_t model(input int dw, input logic [2:0] op, input int off,
                                   input logic [63:0] data, input logic [4:0] tag);
        res_t        r;
        int          size;
        bit          ill;
        bit          mis;
        logic [127:0] field;
        size  = 1 << op[1:0];
        ill   = (op == 3'b111) || (dw == 32 && (op == 3'b011 || op == 3'b110));
        mis   = !ill && ((off % size) != 0);
        field = 128'(data) >> (8 * off);
        field = field & ((128'd1 << (8 * size)) - 128'd1);
        if (!op[2] && field[8 * size - 1]) begin
            field = field - (128'd1 << (8 * size));
        end
        field  = field & ((128'd1 << dw) - 128'd1);
        r.data = (ill || mis) ? 64'd0 : field[63:0];
        r.tag  = tag;
        r.mis  = mis;
        r.ill  = ill;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rv64, input bit valid, input logic [2:0] op,
                         input logic [2:0] off, input logic [63:0] data, input logic [4:0] tag);
        if (rv64) begin
            bus64.in_valid = valid;
            bus64.in_op    = op;
            bus64.in_off   = off;
            bus64.in_data  = data;
            bus64.in_tag   = tag;
        end else begin
            bus32.in_valid = valid;
            bus32.in_op    = op;
            bus32.in_off   = off[1:0];
            bus32.in_data  = data[31:0];
            bus32.in_tag   = tag;
        end
    endtask

    task automatic sample(input bit rv64, output res_t r, output logic valid, output logic rdy);
        if (rv64) begin
            r     = {bus64.out_data, bus64.out_tag, bus64.out_misaligned, bus64.out_illegal};
            valid = bus64.out_valid;
            rdy   = bus64.in_ready;
        end else begin
            r     = {64'(bus32.out_data), bus32.out_tag, bus32.out_misaligned, bus32.out_illegal};
            valid = bus32.out_valid;
            rdy   = bus32.in_ready;
        end
    endtask

    // Scoreboard: on the falling edge, predict what the coming rising edge will transfer.
    task automatic mon(input bit rv64);
        res_t got, exp;
        logic v, rdy, ordy, ivalid;
        int   n;
        sample(rv64, got, v, rdy);
        n      = rv64 ? q64.size() : q32.size();
        ordy   = rv64 ? bus64.out_ready : bus32.out_ready;
        ivalid = rv64 ? bus64.in_valid : bus32.in_valid;
        check($sformatf("mon_out_valid_%0d", rv64 ? 64 : 32), 64'(v), 64'(n > 0));
        check($sformatf("mon_in_ready_%0d", rv64 ? 64 : 32), 64'(rdy), 64'(n < 2));
        if (v && ordy && n > 0) begin
            exp = rv64 ? q64.pop_front() : q32.pop_front();
            check($sformatf("mon_data_%0d", rv64 ? 64 : 32), got.data, exp.data);
            check($sformatf("mon_tag_flags_%0d", rv64 ? 64 : 32),
                  64'({got.tag, got.mis, got.ill}), 64'({exp.tag, exp.mis, exp.ill}));
        end
        if (ivalid && rdy) begin
            if (rv64) q64.push_back(model(64, bus64.in_op, int'(bus64.in_off), bus64.in_data, bus64.in_tag));
            else      q32.push_back(model(32, bus32.in_op, int'(bus32.in_off), 64'(bus32.in_data), bus32.in_tag));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            q64.delete();
        end else begin
            mon(1'b0);
            mon(1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[23];
    res_t r;
    logic v, rdy;
    logic [63:0] held_data;

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 3'd0, 64'h80F1_7F82, 64'h0000_0000_FFFF_FF82, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'b100, 3'd0, 64'h80F1_7F82, 64'h0000_0000_0000_0082, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 3'd1, 64'h80F1_7F82, 64'h0000_0000_0000_007F, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b001, 3'd2, 64'h80F1_7F82, 64'h0000_0000_FFFF_80F1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 3'b101, 3'd2, 64'h80F1_7F82, 64'h0000_0000_0000_80F1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b010, 3'd0, 64'h80F1_7F82, 64'h0000_0000_80F1_7F82, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b000, 3'd3, 64'h80F1_7F82, 64'h0000_0000_FFFF_FF80, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b001, 3'd1, 64'h80F1_7F82, 64'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 3'b010, 3'd2, 64'h80F1_7F82, 64'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 3'b011, 3'd0, 64'h80F1_7F82, 64'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 3'b111, 3'd1, 64'h80F1_7F82, 64'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 3'b110, 3'd0, 64'h80F1_7F82, 64'd0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 3'b101, 3'd3, 64'h80F1_7F82, 64'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 3'b010, 3'd4, 64'h8000_0001_FFFF_FFFE, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 3'b110, 3'd4, 64'h8000_0001_FFFF_FFFE, 64'h0000_0000_8000_0001, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 3'b011, 3'd0, 64'h8000_0001_FFFF_FFFE, 64'h8000_0001_FFFF_FFFE, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 3'b011, 3'd4, 64'h8000_0001_FFFF_FFFE, 64'd0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 3'b000, 3'd7, 64'h8000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 3'b101, 3'd6, 64'h8000_0001_FFFF_FFFE, 64'h0000_0000_0000_8000, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 3'b001, 3'd0, 64'h8000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 3'b111, 3'd0, 64'h8000_0001_FFFF_FFFE, 64'd0, 1'b0, 1'b1};
        vecs[21] = '{1'b1, 3'b110, 3'd2, 64'h8000_0001_FFFF_FFFE, 64'd0, 1'b1, 1'b0};
        vecs[22] = '{1'b1, 3'b100, 3'd1, 64'h8000_0001_FFFF_FFFE, 64'h0000_0000_0000_00FF, 1'b0, 1'b0};

        drive(1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        drive(1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        bus32.out_ready = 1'b1;
        bus64.out_ready = 1'b1;

        // Reset state.
        #1;
        for (int d = 0; d < 2; d++) begin
            sample(d == 1, r, v, rdy);
            check("reset_out_valid", 64'(v), 64'd0);
            check("reset_in_ready", 64'(rdy), 64'd0);
            check("reset_out_fields", 64'(r), 64'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("release_in_ready32", 64'(bus32.in_ready), 64'd1);
        check("release_in_ready64", 64'(bus64.in_ready), 64'd1);

        // Directed vectors, one-cycle latency checked on each.
        for (int i = 0; i < $size(vecs); i++) begin
            drive(vecs[i].rv64, 1'b1, vecs[i].op, vecs[i].off, vecs[i].data, 5'(i));
            tick();
            drive(vecs[i].rv64, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
            sample(vecs[i].rv64, r, v, rdy);
            check($sformatf("vec%0d_valid", i), 64'(v), 64'd1);
            check($sformatf("vec%0d_data", i), r.data, vecs[i].exp_data);
            check($sformatf("vec%0d_tag_flags", i), 64'({r.tag, r.mis, r.ill}),
                  64'({5'(i), vecs[i].exp_mis, vecs[i].exp_ill}));
        end
        tick();

        // Backpressure on the RV32 instance: tags 1 and 2 accepted, 3 held.
        bus32.out_ready = 1'b0;
        drive(1'b0, 1'b1, 3'b010, 3'd0, 64'h1111_1111, 5'd1);
        tick();
        check("bp_ready_after_1", 64'(bus32.in_ready), 64'd1);
        check("bp_tag_after_1", 64'(bus32.out_tag), 64'd1);
        drive(1'b0, 1'b1, 3'b010, 3'd0, 64'h2222_2222, 5'd2);
        tick();
        check("bp_ready_full", 64'(bus32.in_ready), 64'd0);
        drive(1'b0, 1'b1, 3'b010, 3'd0, 64'h3333_3333, 5'd3);
        held_data = 64'(bus32.out_data);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("bp_hold_ready", 64'(bus32.in_ready), 64'd0);
            check("bp_hold_tag", 64'(bus32.out_tag), 64'd1);
            check("bp_hold_data", 64'(bus32.out_data), held_data);
        end
        bus32.out_ready = 1'b1;
        tick();
        check("bp_drain_valid_2", 64'(bus32.out_valid), 64'd1);
        check("bp_drain_tag_2", 64'(bus32.out_tag), 64'd2);
        check("bp_recover_ready", 64'(bus32.in_ready), 64'd1);
        tick();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        check("bp_drain_valid_3", 64'(bus32.out_valid), 64'd1);
        check("bp_drain_tag_3", 64'(bus32.out_tag), 64'd3);
        tick();
        check("bp_empty", 64'(bus32.out_valid), 64'd0);

        // Simultaneous in/out transfers on the RV64 instance: skid never used.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  {$urandom, $urandom}, 5'(10 + k));
            tick();
            check("sim_in_ready", 64'(bus64.in_ready), 64'd1);
            check("sim_out_valid", 64'(bus64.out_valid), 64'd1);
            check("sim_out_tag", 64'(bus64.out_tag), 64'(10 + k));
        end
        drive(1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        tick();
        check("sim_empty", 64'(bus64.out_valid), 64'd0);

        // Reset while both instances sit in FULL2.
        bus32.out_ready = 1'b0;
        bus64.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 3'b010, 3'd0, 64'hDEAD_BEEF, 5'(20 + k));
            drive(1'b1, 1'b1, 3'b011, 3'd0, 64'hCAFE_F00D_DEAD_BEEF, 5'(20 + k));
            tick();
        end
        drive(1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        drive(1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        check("rst_pre_ready64", 64'(bus64.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            sample(d == 1, r, v, rdy);
            check("rst_async_out_valid", 64'(v), 64'd0);
            check("rst_async_in_ready", 64'(rdy), 64'd0);
            check("rst_async_fields", 64'(r), 64'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        bus64.out_ready = 1'b1;
        #1;
        check("rst_rel_ready32", 64'(bus32.in_ready), 64'd1);
        check("rst_rel_ready64", 64'(bus64.in_ready), 64'd1);
        drive(1'b0, 1'b1, 3'b000, 3'd2, 64'h0055_0000, 5'd25);
        drive(1'b1, 1'b1, 3'b001, 3'd6, 64'hFF00_0000_0000_0000, 5'd26);
        tick();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        drive(1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        check("rst_first32_tag", 64'(bus32.out_tag), 64'd25);
        check("rst_first32_data", 64'(bus32.out_data), 64'h55);
        check("rst_first64_tag", 64'(bus64.out_tag), 64'd26);
        check("rst_first64_data", bus64.out_data, 64'hFFFF_FFFF_FFFF_FF00);
        tick();
        check("rst_after32_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_after64_valid", 64'(bus64.out_valid), 64'd0);

        // Random traffic on both instances against the queue model.
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d == 1, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), {$urandom, $urandom}, 5'($urandom_range(0, 31)));
            end
            bus32.out_ready = $urandom_range(0, 9) < 6;
            bus64.out_ready = $urandom_range(0, 9) < 6;
            tick();
        end
        drive(1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        drive(1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 5'd0);
        bus32.out_ready = 1'b1;
        bus64.out_ready = 1'b1;
        for (int k = 0; k < 10 && (q32.size() != 0 || q64.size() != 0); k++) begin
            tick();
        end
        check("drain_q32", 64'(q32.size()), 64'd0);
        check("drain_q64", 64'(q64.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
